// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: RV32I opcodes, funct3 values,
// the MEM-stage operation code and common constants.
package ex_stage_pkg;

    localparam logic [6:0] OPC_ADDI   = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand bundle in, EX/MEM latch and forwarding path out.
interface ex_stage_if;
    logic        rdy_in;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] pc;
    logic [31:0] r1_data;
    logic [31:0] r2_data;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic        ins_diff;

    logic        forward_ex_enable;
    logic [4:0]  forward_ex_addr;
    logic [31:0] forward_ex_data;
    logic        out_rd_enable;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [1:0]  out_mem_op;
    logic [2:0]  out_funct3;
    logic        jump_enable;
    logic [31:0] jump_target;

    modport slave (
        input  rdy_in, stall_in, flush_in, pc, r1_data, r2_data, rd_addr,
               imm, ins_type, ins_details, ins_diff,
        output forward_ex_enable, forward_ex_addr, forward_ex_data,
               out_rd_enable, out_rd_addr, out_result, out_store_data,
               out_mem_op, out_funct3, jump_enable, jump_target
    );

    modport master (
        output rdy_in, stall_in, flush_in, pc, r1_data, r2_data, rd_addr,
               imm, ins_type, ins_details, ins_diff,
        input  forward_ex_enable, forward_ex_addr, forward_ex_data,
               out_rd_enable, out_rd_addr, out_result, out_store_data,
               out_mem_op, out_funct3, jump_enable, jump_target
    );
endinterface

// File: rtl/ex_alu.sv
// Combinational result, target and branch-condition unit for the execute stage.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        diff,
    output logic [31:0] result,
    output logic [31:0] target,
    output logic        taken,
    output logic        writes_rd,
    output logic        known,
    output logic [1:0]  mem_op
);
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic        br_cond;

    assign opb   = (opcode == OPC_OP) ? r2 : imm;
    assign shamt = opb[4:0];

    // SUB exists only for register-register; SRAI still uses diff via imm[10].
    always_comb begin
        alu_out = ZERO_WORD;
        case (funct3)
            F3_ADD:  alu_out = (opcode == OPC_OP && diff) ? r1 - opb : r1 + opb;
            F3_SLL:  alu_out = r1 << shamt;
            F3_SLT:  alu_out = {31'b0, ($signed(r1) < $signed(opb))};
            F3_SLTU: alu_out = {31'b0, (r1 < opb)};
            F3_XOR:  alu_out = r1 ^ opb;
            F3_SR:   alu_out = diff ? $unsigned($signed(r1) >>> shamt) : r1 >> shamt;
            F3_OR:   alu_out = r1 | opb;
            F3_AND:  alu_out = r1 & opb;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = (r1 == r2);
            F3_BNE:  br_cond = (r1 != r2);
            F3_BLT:  br_cond = ($signed(r1) < $signed(r2));
            F3_BGE:  br_cond = ($signed(r1) >= $signed(r2));
            F3_BLTU: br_cond = (r1 < r2);
            F3_BGEU: br_cond = (r1 >= r2);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        result    = ZERO_WORD;
        target    = pc + imm;
        taken     = 1'b0;
        writes_rd = 1'b0;
        known     = 1'b1;
        mem_op    = MEM_NONE;
        case (opcode)
            OPC_OP, OPC_ADDI: begin
                result    = alu_out;
                writes_rd = 1'b1;
            end
            OPC_LUI: begin
                result    = imm;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                result    = pc + imm;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                result    = pc + 32'd4;
                taken     = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                result    = pc + 32'd4;
                target    = (r1 + imm) & 32'hFFFF_FFFE;
                taken     = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: taken = br_cond;
            OPC_LOAD: begin
                result    = r1 + imm;
                writes_rd = 1'b1;
                mem_op    = MEM_LOAD;
            end
            OPC_STORE: begin
                result = r1 + imm;
                mem_op = MEM_STORE;
            end
            default: known = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: EX/MEM latch with stall/flush handling, wrong-path squash
// after taken control transfers, and the combinational EX forwarding path.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int SQUASH_CYCLES = 1,
    parameter int SQUASH_W      = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    ex_stage_if.slave  bus
);
    logic [SQUASH_W-1:0] squash_cnt;
    logic [31:0] result;
    logic [31:0] target;
    logic        taken;
    logic        writes_rd;
    logic        known;
    logic [1:0]  mem_op;
    logic        bubble;
    logic        take_jump;
    logic        wr_ok;

    ex_alu u_alu (
        .pc        (bus.pc),
        .r1        (bus.r1_data),
        .r2        (bus.r2_data),
        .imm       (bus.imm),
        .opcode    (bus.ins_type),
        .funct3    (bus.ins_details),
        .diff      (bus.ins_diff),
        .result    (result),
        .target    (target),
        .taken     (taken),
        .writes_rd (writes_rd),
        .known     (known),
        .mem_op    (mem_op)
    );

    assign bubble    = bus.flush_in | (squash_cnt != '0) | ~known;
    assign take_jump = taken & ~bubble;
    assign wr_ok     = writes_rd & (bus.rd_addr != 5'd0) & ~bubble;

    // Load data is not available until MEM, so loads never forward from EX.
    assign bus.forward_ex_enable = wr_ok & (mem_op != MEM_LOAD) & ~rst_in;
    assign bus.forward_ex_addr   = bus.rd_addr;
    assign bus.forward_ex_data   = result;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.out_rd_enable  <= 1'b0;
            bus.out_rd_addr    <= 5'd0;
            bus.out_result     <= ZERO_WORD;
            bus.out_store_data <= ZERO_WORD;
            bus.out_mem_op     <= MEM_NONE;
            bus.out_funct3     <= 3'd0;
            bus.jump_enable    <= 1'b0;
            bus.jump_target    <= ZERO_WORD;
            squash_cnt         <= '0;
        end else if (bus.rdy_in) begin
            if (bus.stall_in) begin
                bus.jump_enable <= 1'b0;
            end else begin
                bus.out_rd_enable  <= wr_ok;
                bus.out_rd_addr    <= bus.rd_addr;
                bus.out_result     <= result;
                bus.out_store_data <= bus.r2_data;
                bus.out_mem_op     <= bubble ? MEM_NONE : mem_op;
                bus.out_funct3     <= bus.ins_details;
                bus.jump_enable    <= take_jump;
                bus.jump_target    <= target;
                if (bus.flush_in)
                    squash_cnt <= '0;
                else if (take_jump)
                    squash_cnt <= SQUASH_W'(SQUASH_CYCLES);
                else if (squash_cnt != '0)
                    squash_cnt <= squash_cnt - SQUASH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage against an instruction-level model.
module tb_ex_stage;
    localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, LUI = 7'h37, AUI = 7'h17;
    localparam logic [6:0] JAL = 7'h6f, JALR = 7'h67, BR = 7'h63, LD = 7'h03, ST = 7'h23;
    localparam int SQ = 1;

    typedef struct {
        logic rst, rdy, stall, flush;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0] rd;
        logic [6:0] op;
        logic [2:0] f3;
        logic diff;
    } stim_t;

    typedef struct {
        logic rd_en;
        logic [4:0] rd;
        logic [31:0] result, store, target;
        logic [1:0] mop;
        logic [2:0] f3;
        logic jump;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    exp_t lat;
    int sq = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage #(.SQUASH_CYCLES(SQ), .SQUASH_W(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Instruction semantics straight from the ISA definition.
    task automatic ref_eval(input stim_t s, output logic [31:0] res, output logic [31:0] tgt,
                            output bit tk, output bit wr, output bit kn, output logic [1:0] mop);
        logic [31:0] b;
        b = (s.op == OPR) ? s.r2 : s.imm;
        res = 0; tgt = s.pc + s.imm; tk = 0; wr = 0; kn = 1; mop = 0;
        if (s.op == OPR || s.op == OPI) begin
            wr = 1;
            case (s.f3)
                3'd0: res = (s.op == OPR && s.diff) ? s.r1 - b : s.r1 + b;
                3'd1: res = s.r1 << b[4:0];
                3'd2: res = ($signed(s.r1) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (s.r1 < b) ? 32'd1 : 32'd0;
                3'd4: res = s.r1 ^ b;
                3'd5: res = s.diff ? 32'($signed(s.r1) >>> b[4:0]) : s.r1 >> b[4:0];
                3'd6: res = s.r1 | b;
                default: res = s.r1 & b;
            endcase
        end else if (s.op == LUI) begin res = s.imm; wr = 1; end
        else if (s.op == AUI) begin res = s.pc + s.imm; wr = 1; end
        else if (s.op == JAL) begin res = s.pc + 4; tk = 1; wr = 1; end
        else if (s.op == JALR) begin
            res = s.pc + 4; tk = 1; wr = 1;
            tgt = s.r1 + s.imm; tgt[0] = 1'b0;
        end else if (s.op == BR) begin
            case (s.f3)
                3'd0: tk = (s.r1 == s.r2);
                3'd1: tk = (s.r1 != s.r2);
                3'd4: tk = ($signed(s.r1) < $signed(s.r2));
                3'd5: tk = ($signed(s.r1) >= $signed(s.r2));
                3'd6: tk = (s.r1 < s.r2);
                3'd7: tk = (s.r1 >= s.r2);
                default: tk = 0;
            endcase
        end else if (s.op == LD) begin res = s.r1 + s.imm; wr = 1; mop = 2'd1; end
        else if (s.op == ST) begin res = s.r1 + s.imm; mop = 2'd2; end
        else kn = 0;
    endtask

    task automatic step(input stim_t s);
        logic [31:0] res, tgt;
        bit tk, wr, kn, bub, fwd;
        logic [1:0] mop;
        @(negedge clk);
        rst = s.rst;
        bus.rdy_in = s.rdy; bus.stall_in = s.stall; bus.flush_in = s.flush;
        bus.pc = s.pc; bus.r1_data = s.r1; bus.r2_data = s.r2; bus.imm = s.imm;
        bus.rd_addr = s.rd; bus.ins_type = s.op; bus.ins_details = s.f3; bus.ins_diff = s.diff;
        ref_eval(s, res, tgt, tk, wr, kn, mop);
        bub = s.flush || sq != 0 || !kn;
        fwd = !s.rst && !bub && wr && s.rd != 0 && mop != 2'd1;
        if (s.rst) begin
            lat = '{default: '0};
            sq = 0;
        end else if (s.rdy) begin
            if (s.stall) lat.jump = 0;
            else begin
                lat.rd_en = !bub && wr && s.rd != 0;
                lat.rd = s.rd; lat.result = res; lat.store = s.r2;
                lat.mop = bub ? 2'd0 : mop; lat.f3 = s.f3;
                lat.jump = !bub && tk; lat.target = tgt;
                if (s.flush) sq = 0;
                else if (lat.jump) sq = SQ;
                else if (sq > 0) sq--;
            end
        end
        sbq.push_back(lat);
        #1;
        chk("fwd_en", 32'(bus.forward_ex_enable), 32'(fwd));
        if (fwd) begin
            chk("fwd_addr", 32'(bus.forward_ex_addr), 32'(s.rd));
            chk("fwd_data", bus.forward_ex_data, res);
        end
    endtask

    function automatic stim_t mk(logic [6:0] op, logic [2:0] f3, logic diff, logic [31:0] r1,
                                 logic [31:0] r2, logic [31:0] imm, logic [4:0] rd, logic [31:0] pc);
        stim_t s;
        s.rst = 0; s.rdy = 1; s.stall = 0; s.flush = 0;
        s.op = op; s.f3 = f3; s.diff = diff; s.r1 = r1; s.r2 = r2;
        s.imm = imm; s.rd = rd; s.pc = pc;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        logic [6:0] ops [10];
        ops = '{OPI, OPR, LUI, AUI, JAL, JALR, BR, LD, ST, 7'h7f};
        s.rst   = ($urandom_range(0, 199) == 0);
        s.rdy   = ($urandom_range(0, 9) != 0);
        s.stall = ($urandom_range(0, 4) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.op    = ops[$urandom_range(0, 9)];
        s.f3    = 3'($urandom); s.diff = 1'($urandom);
        s.r1    = $urandom;
        s.r2    = ($urandom_range(0, 3) == 0) ? s.r1 : $urandom;
        s.imm   = $urandom; s.rd = 5'($urandom); s.pc = $urandom & 32'hFFFF_FFFC;
        return s;
    endfunction

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rd_en", 32'(bus.out_rd_enable), 32'(e.rd_en));
                chk("rd_addr", 32'(bus.out_rd_addr), 32'(e.rd));
                chk("mem_op", 32'(bus.out_mem_op), 32'(e.mop));
                chk("funct3", 32'(bus.out_funct3), 32'(e.f3));
                chk("jump_en", 32'(bus.jump_enable), 32'(e.jump));
                if (e.rd_en || e.mop != 0) chk("result", bus.out_result, e.result);
                if (e.mop == 2'd2) chk("store_data", bus.out_store_data, e.store);
                if (e.jump) chk("jump_target", bus.jump_target, e.target);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        for (int i = 0; i < 2; i++) begin
            s = rnd(); s.rst = 1; step(s);
        end
        post();
        chk("rst_rd_en", 32'(bus.out_rd_enable), 0);
        chk("rst_result", bus.out_result, 0);
        chk("rst_jump", 32'(bus.jump_enable), 0);

        step(mk(OPR, 0, 0, 5, 7, 0, 3, 0)); post();
        chk("add_result", bus.out_result, 12);
        chk("add_rd", 32'(bus.out_rd_addr), 3);
        step(mk(OPR, 0, 1, 3, 5, 0, 4, 0)); post();
        chk("sub_result", bus.out_result, 32'hFFFF_FFFE);
        step(mk(OPR, 5, 1, 32'h8000_0000, 31, 0, 4, 0)); post();
        chk("sra_result", bus.out_result, 32'hFFFF_FFFF);
        step(mk(OPR, 3, 0, 1, 32'hFFFF_FFFF, 0, 4, 0)); post();
        chk("sltu_result", bus.out_result, 1);

        step(mk(BR, 0, 0, 9, 9, 32'h20, 0, 32'h100)); post();
        chk("beq_jump", 32'(bus.jump_enable), 1);
        chk("beq_target", bus.jump_target, 32'h120);
        step(mk(OPR, 0, 0, 1, 1, 0, 6, 0)); post();
        chk("squash_jump", 32'(bus.jump_enable), 0);
        chk("squash_rd_en", 32'(bus.out_rd_enable), 0);
        step(mk(OPR, 0, 0, 1, 1, 0, 6, 0)); post();
        chk("after_squash_rd_en", 32'(bus.out_rd_enable), 1);
        chk("after_squash_result", bus.out_result, 2);

        s = mk(JAL, 0, 0, 0, 0, 8, 1, 32'h40);
        s.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(s); post();
            chk("stall_jump", 32'(bus.jump_enable), 0);
            chk("stall_hold_rd", 32'(bus.out_rd_addr), 6);
        end
        s.stall = 0;
        step(s); post();
        chk("jal_jump", 32'(bus.jump_enable), 1);
        chk("jal_target", bus.jump_target, 32'h48);
        chk("jal_result", bus.out_result, 32'h44);
        step(mk(OPR, 0, 0, 2, 2, 0, 7, 0)); post();
        chk("jal_pulse_end", 32'(bus.jump_enable), 0);

        s = mk(BR, 1, 0, 1, 2, 16, 0, 32'h200);
        s.flush = 1;
        step(s); post();
        chk("flush_jump", 32'(bus.jump_enable), 0);
        chk("flush_mem_op", 32'(bus.out_mem_op), 0);

        step(mk(LD, 2, 0, 32'h1000, 0, 32'hFFFF_FFFC, 5, 0));
        chk("lw_fwd_en", 32'(bus.forward_ex_enable), 0);
        post();
        chk("lw_result", bus.out_result, 32'hFFC);
        chk("lw_mem_op", 32'(bus.out_mem_op), 1);
        step(mk(OPI, 0, 0, 3, 0, 7, 0, 0));
        chk("addi_x0_fwd", 32'(bus.forward_ex_enable), 0);
        post();
        chk("addi_x0_rd_en", 32'(bus.out_rd_enable), 0);

        for (int i = 0; i < 2000; i++) step(rnd());
        @(posedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I core; sits directly downstream of the ID/EX pipeline register.
- Computes ALU results, effective load/store addresses and branch/jump outcomes.
- Drives the combinational EX forwarding path back into ID/EX.
- Registers its results into the EX/MEM latch, including stall hold, flush, and wrong-path squash after taken control transfers.

Parameters:
- SQUASH_CYCLES, 1: number of accepted instructions discarded after a taken branch/jump (wrong-path slots in flight).
- SQUASH_W, 2: width of the squash counter; must hold SQUASH_CYCLES.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low = freeze all state
- stall_in  input  1  MEM stage busy; hold the EX/MEM latch
- flush_in  input  1  controller kill; current input becomes bubble
- pc  input  32  pc of instruction in EX
- r1_data  input  32  forwarded rs1 value
- r2_data  input  32  forwarded rs2 value
- rd_addr  input  5  destination register
- imm  input  32  sign-extended immediate
- ins_type  input  7  opcode
- ins_details  input  3  funct3
- ins_diff  input  1  funct7[5]
- forward_ex_enable  output  1  combinational: current instruction writes rd and is not a load
- forward_ex_addr  output  5  combinational rd
- forward_ex_data  output  32  combinational result
- out_rd_enable  output  1  registered writeback enable
- out_rd_addr  output  5  registered rd
- out_result  output  32  ALU result, or memory address for load/store
- out_store_data  output  32  r2_data for stores
- out_mem_op  output  2  0 none, 1 load, 2 store
- out_funct3  output  3  width/sign for MEM
- jump_enable  output  1  one-cycle registered pulse: taken branch/jump
- jump_target  output  32  redirect pc

Behaviour:
- Reset (rst_in=1 at posedge) takes priority over everything: all registered outputs 0, out_mem_op=0, squash counter 0.
- rdy_in=0 without reset: all registers hold; jump_enable holds its value.
- Accept condition: accepted = rdy_in & ~stall_in.
- On accept, the EX/MEM latch loads the computed fields. Latency is one cycle.
- stall_in=1: latch and squash counter hold; jump_enable is forced 0, so no repeated pulse.
- Bubble condition: flush_in, or squash_cnt!=0, or an unknown opcode. A bubble latches out_rd_enable=0, out_mem_op=0 and jump_enable=0, and drives forward_ex_enable=0.
- Squash counter:
  - Loaded with SQUASH_CYCLES on an accepted taken jump.
  - Decrements on each accepted cycle while nonzero.
  - Cleared by flush_in, because the controller already killed the wrong path.
- Flush and jump in the same cycle: flush wins; no jump.
- ALU, all 32-bit wrap-around:
  - OP: add, or sub when diff=1.
  - OP-IMM: add; diff is ignored except for SRAI.
  - Shifts use shamt[4:0]; SRL/SRA selected by diff.
  - SLT is signed; SLTU is unsigned; plus XOR/OR/AND.
- LUI: result = imm.
- AUIPC: result = pc+imm.
- JAL: result = pc+4; target = pc+imm.
- JALR: result = pc+4; target = (r1+imm) & ~1.
- Branches: BEQ/BNE/BLT/BGE/BLTU/BGEU by funct3; target = pc+imm; no rd write.
- Load: result = r1+imm, mem_op=1, rd_enable=1.
- Store: result = r1+imm, store_data=r2, mem_op=2, rd_enable=0.
- rd_addr==0 forces rd_enable=0 and forward_ex_enable=0.
- forward_ex_enable=0 for loads, since load data is not yet available.

Decomposition:
- Shared package/defines holds:
  - opcode constants (ADDI, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE);
  - funct3 encodings;
  - the mem_op encoding;
  - ZeroWord.
- Sub-module ex_alu: purely combinational result and branch-condition unit. The ex_stage top holds the latch, squash counter and forwarding logic.

Test Plan:
- Reset with random inputs held: all outputs 0, forward_ex_enable=0; first accepted ADD r3=5+7 gives out_result=12, out_rd_addr=3 one cycle later.
- SUB r1=3,r2=5, diff=1: result 0xFFFFFFFE. SRA 0x80000000 by 31: 0xFFFFFFFF. SLTU 1<0xFFFFFFFF: 1.
- BEQ at pc=0x100, imm=0x20, equal operands: jump_enable=1 for exactly one cycle with target 0x120; next accepted ADD is bubbled (rd_enable=0); the following ADD is latched normally.
- stall_in held 3 cycles during a taken JAL at pc=0x40, imm=8:
  - latch holds and jump_enable stays 0 throughout;
  - on release, a single pulse with target 0x48 and out_result 0x44.
- flush_in with a taken BNE: no jump, bubble latched.
- LW with r1=0x1000, imm=-4: out_result 0xFFC, mem_op=1, forward_ex_enable=0. ADDI with rd=0: forward and rd_enable both 0.
